// File: rtl/mem_rd_responder.sv
// Memory-side read responder: issues fixed-latency SRAM reads and returns words through a credit-guarded FIFO.
// Build option: define MEM_RD_OUT_REG_EN for a registered SRAM output (RD_LAT=2); default RD_LAT=1.
module mem_rd_responder #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     mem_rd_en,
  input  logic [ADDR_WIDTH-1:0]                    mem_rd_addr,
  input  logic                                     mem_rd_last,
  output logic                                     mem_rd_ready,
  output logic [DATA_WIDTH-1:0]                    mem_rd_data,
  output logic                                     mem_rd_data_last,
  output logic                                     mem_rd_data_v,
  input  logic                                     mem_rd_data_ready,
  output logic                                     ram_en,
  output logic [ADDR_WIDTH-$clog2(STRB_WIDTH)-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]                    ram_dout,
  output logic                                     pkt_done
);

`ifdef MEM_RD_OUT_REG_EN
  localparam int unsigned RD_LAT = 2;
`else
  localparam int unsigned RD_LAT = 1;
`endif
  localparam int unsigned OFF_W  = $clog2(STRB_WIDTH);
  localparam int unsigned LINE_W = ADDR_WIDTH - OFF_W;
  localparam int unsigned IDX_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic              init_q;
  logic [PTR_W-1:0]  credit_q, credit_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;
  logic [RD_LAT-1:0] pipe_l_q, pipe_l_d;
  logic              pkt_done_q, pkt_done_d;
  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            head;
  logic              accept, pop, wr_en, not_empty;

  // Ready is held low until the first edge after reset release.
  assign mem_rd_ready = init_q & (credit_q != '0);
  assign accept       = mem_rd_en & mem_rd_ready;
  assign ram_en       = accept;
  assign ram_addr     = accept ? LINE_W'(mem_rd_addr >> OFF_W) : '0;

  assign not_empty        = (wr_ptr_q != rd_ptr_q);
  assign pop              = not_empty & mem_rd_data_ready;
  assign wr_en            = pipe_v_q[RD_LAT-1];
  assign head             = fifo_q[rd_ptr_q[IDX_W-1:0]];
  assign mem_rd_data_v    = not_empty;
  assign mem_rd_data      = not_empty ? head.data : '0;
  assign mem_rd_data_last = not_empty & head.last;
  assign pkt_done         = pkt_done_q;

  // Credit, pointer and in-flight pipe next state.
  always_comb begin
    credit_d   = credit_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pipe_v_d   = RD_LAT'({pipe_v_q, accept});
    pipe_l_d   = RD_LAT'({pipe_l_q, accept & mem_rd_last});
    pkt_done_d = pop & head.last;
    if (accept && !pop) begin
      credit_d = credit_q - PTR_W'(1);
    end else if (pop && !accept) begin
      credit_d = credit_q + PTR_W'(1);
    end
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      credit_q   <= PTR_W'(FIFO_DEPTH);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pipe_v_q   <= '0;
      pipe_l_q   <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      init_q     <= 1'b1;
      credit_q   <= credit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pipe_v_q   <= pipe_v_d;
      pipe_l_q   <= pipe_l_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // Storage needs no reset: occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_q[wr_ptr_q[IDX_W-1:0]] <= {pipe_l_q[RD_LAT-1], ram_dout};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (credit_q <= PTR_W'(FIFO_DEPTH)) else $error("credit above FIFO depth");
      assert (!(wr_en && ((wr_ptr_q - rd_ptr_q) == PTR_W'(FIFO_DEPTH))))
        else $error("write into full return FIFO");
    end
  end

endmodule

// File: tb/tb_mem_rd_responder.sv
// Self-checking bench for mem_rd_responder: SRAM model, accept/pop scoreboard, per-feature test tasks.
`timescale 1ns/1ps
module tb_mem_rd_responder;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 13;
`ifdef MEM_RD_OUT_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_rd_en = 1'b0;
  logic [AW-1:0] mem_rd_addr = '0;
  logic          mem_rd_last = 1'b0;
  logic          mem_rd_ready;
  logic [63:0]   mem_rd_data;
  logic          mem_rd_data_last;
  logic          mem_rd_data_v;
  logic          mem_rd_data_ready = 1'b0;
  logic          ram_en;
  logic [LW-1:0] ram_addr;
  logic [63:0]   ram_dout;
  logic          pkt_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mcredit = 4;
  int ready_err = 0;
  int pd_cnt = 0;
  int pd_cyc = -100;
  int last_pop_cyc = -100;
  bit seen_edge = 1'b0;
  word_t exp_q[$];
  word_t obs_q[$];

  mem_rd_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_last      (mem_rd_last),
    .mem_rd_ready     (mem_rd_ready),
    .mem_rd_data      (mem_rd_data),
    .mem_rd_data_last (mem_rd_data_last),
    .mem_rd_data_v    (mem_rd_data_v),
    .mem_rd_data_ready(mem_rd_data_ready),
    .ram_en           (ram_en),
    .ram_addr         (ram_addr),
    .ram_dout         (ram_dout),
    .pkt_done         (pkt_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] line_data(input logic [LW-1:0] a);
    return {16'hC0DE, 3'b000, a, 3'b111, ~a, 16'(a) ^ 16'h5A5A};
  endfunction

  // SRAM model: data valid RD_LAT cycles after ram_en, garbage otherwise.
  logic [63:0] rd_s1 = '0;
  logic [63:0] rd_s2 = '0;
  always @(posedge clk) begin
    rd_s1 <= ram_en ? line_data(ram_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    rd_s2 <= rd_s1;
  end
  assign ram_dout = (RD_LAT == 2) ? rd_s2 : rd_s1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen_edge <= 1'b0;
    else        seen_edge <= 1'b1;
  end

  // Scoreboard feed and credit model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (seen_edge && (mem_rd_ready !== (mcredit != 0))) ready_err++;
      if (mem_rd_en && mem_rd_ready) begin
        exp_q.push_back({mem_rd_last, line_data(mem_rd_addr[AW-1:3])});
        mcredit--;
      end
      if (mem_rd_data_v && mem_rd_data_ready) begin
        obs_q.push_back({mem_rd_data_last, mem_rd_data});
        mcredit++;
        if (mem_rd_data_last) last_pop_cyc = cyc;
      end
      if (mcredit < 0 || mcredit > 4) ready_err++;
      if (pkt_done) begin
        pd_cnt++;
        pd_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mem_rd_en = 1'b1;
    mem_rd_addr = 16'h0040;
    mem_rd_data_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_rd_ready !== 1'b0 || mem_rd_data_v !== 1'b0 || ram_en !== 1'b0 || pkt_done !== 1'b0 ||
        mem_rd_data !== 64'h0 || ram_addr !== '0 || mem_rd_data_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b v=%b ram_en=%b pkt_done=%b data=%h ram_addr=%h expected all zero",
               mem_rd_ready, mem_rd_data_v, ram_en, pkt_done, mem_rd_data, ram_addr);
    end
    mem_rd_en = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_rd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_pre_edge got=%b expected=0", mem_rd_ready);
    end
    @(negedge clk);
    checks++;
    if (mem_rd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_post_edge got=%b expected=1", mem_rd_ready);
    end
    tick();
  endtask

  task automatic test_streaming();
    int v_cyc = -1;
    word_t o, e;
    mem_rd_data_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      mem_rd_en = (c < 4);
      mem_rd_addr = 16'(c * 8);
      mem_rd_last = 1'b0;
      @(negedge clk);
      if (c < 4) begin
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== LW'(c) || mem_rd_ready !== 1'b1) begin
          failures++;
          $display("FAIL stream_accept c=%0d ram_en=%b ram_addr=%h ready=%b expected 1/%h/1",
                   c, ram_en, ram_addr, mem_rd_ready, LW'(c));
        end
      end
      if (mem_rd_data_v && v_cyc < 0) v_cyc = c;
      tick();
    end
    mem_rd_en = 1'b0;
    checks++;
    if (v_cyc != RD_LAT + 1) begin
      failures++;
      $display("FAIL stream_latency got=%0d expected=%0d", v_cyc, RD_LAT + 1);
    end
    checks++;
    if (obs_q.size() != 4 || exp_q.size() != 4) begin
      failures++;
      $display("FAIL stream_count got=%0d/%0d expected=4", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stream_word got=%b/%h expected=%b/%h", o.last, o.data, e.last, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int j = 0;
    int acc = 0;
    logic [63:0] held;
    word_t o, e;
    mem_rd_data_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      mem_rd_en = 1'b1;
      mem_rd_addr = 16'h0200 + 16'(j * 8);
      @(negedge clk);
      if (mem_rd_ready) begin
        j++;
        acc++;
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (acc != 4 || mem_rd_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_credit_stall accepted=%0d ready=%b expected 4/0", acc, mem_rd_ready);
    end
    held = mem_rd_data;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_rd_data !== held || mem_rd_data_v !== 1'b1) begin
      failures++;
      $display("FAIL bp_head_stable got=%h v=%b expected=%h v=1", mem_rd_data, mem_rd_data_v, held);
    end
    tick();
    mem_rd_data_ready = 1'b1;
    for (int c = 0; c < 40 && j < 6; c++) begin
      mem_rd_en = 1'b1;
      mem_rd_addr = 16'h0200 + 16'(j * 8);
      @(negedge clk);
      if (mem_rd_ready) j++;
      tick();
    end
    mem_rd_en = 1'b0;
    repeat (10) tick();
    checks++;
    if (j != 6 || obs_q.size() != 6 || exp_q.size() != 6) begin
      failures++;
      $display("FAIL bp_count accepted=%0d out=%0d exp=%0d expected=6", j, obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL bp_word got=%b/%h expected=%b/%h", o.last, o.data, e.last, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_simultaneous();
    int k = 0;
    word_t o, e;
    mem_rd_data_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mem_rd_en = 1'b1;
      mem_rd_addr = 16'h0300 + 16'(k * 8);
      @(negedge clk);
      if (mem_rd_ready) k++;
      tick();
    end
    mem_rd_en = 1'b0;
    repeat (RD_LAT + 2) tick();
    @(negedge clk);
    checks++;
    if (mem_rd_ready !== 1'b0 || mem_rd_data_v !== 1'b1 || k != 4) begin
      failures++;
      $display("FAIL sim_full ready=%b v=%b accepted=%0d expected 0/1/4", mem_rd_ready, mem_rd_data_v, k);
    end
    tick();
    mem_rd_data_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      mem_rd_en = 1'b1;
      mem_rd_addr = 16'h0300 + 16'(k * 8);
      @(negedge clk);
      checks++;
      if (mem_rd_ready !== (c != 0) || mem_rd_data_v !== 1'b1) begin
        failures++;
        $display("FAIL sim_steady c=%0d ready=%b v=%b expected %b/1", c, mem_rd_ready, mem_rd_data_v, (c != 0));
      end
      if (mem_rd_ready) k++;
      tick();
    end
    mem_rd_en = 1'b0;
    repeat (10) tick();
    checks++;
    if (obs_q.size() != 13 || exp_q.size() != 13 || ready_err != 0) begin
      failures++;
      $display("FAIL sim_count out=%0d exp=%0d credit_err=%0d expected 13/13/0", obs_q.size(), exp_q.size(), ready_err);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL sim_word got=%b/%h expected=%b/%h", o.last, o.data, e.last, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_last();
    word_t o, e;
    pd_cnt = 0;
    last_pop_cyc = -100;
    mem_rd_data_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mem_rd_en = 1'b1;
      mem_rd_addr = 16'h0100 + 16'(c * 8);
      mem_rd_last = (c == 2);
      tick();
    end
    mem_rd_en = 1'b0;
    mem_rd_last = 1'b0;
    repeat (8) tick();
    checks++;
    if (obs_q.size() != 3 || obs_q.size() > 2 && (obs_q[0].last !== 1'b0 || obs_q[1].last !== 1'b0 || obs_q[2].last !== 1'b1)) begin
      failures++;
      $display("FAIL last_flags count=%0d expected 3 words with last only on third", obs_q.size());
    end
    checks++;
    if (pd_cnt != 1 || pd_cyc != last_pop_cyc + 1) begin
      failures++;
      $display("FAIL pkt_done pulses=%0d at=%0d expected 1 at %0d", pd_cnt, pd_cyc, last_pop_cyc + 1);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL last_word got=%b/%h expected=%b/%h", o.last, o.data, e.last, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_unaligned();
    word_t o, e;
    mem_rd_data_ready = 1'b1;
    mem_rd_en = 1'b1;
    mem_rd_addr = 16'h0013;
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== 13'h002) begin
      failures++;
      $display("FAIL unaligned_addr ram_en=%b ram_addr=%h expected 1/002", ram_en, ram_addr);
    end
    tick();
    mem_rd_en = 1'b0;
    repeat (6) tick();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].data !== line_data(13'h002)) begin
      failures++;
      $display("FAIL unaligned_data count=%0d expected 1 word of line 2 = %h", obs_q.size(), line_data(13'h002));
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL unaligned_word got=%b/%h expected=%b/%h", o.last, o.data, e.last, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    int acc = 0;
    int vcnt = 0;
    word_t o, e;
    mem_rd_data_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mem_rd_en = 1'b1;
      mem_rd_addr = 16'h0280 + 16'(c * 8);
      tick();
    end
    mem_rd_en = 1'b0;
    repeat (RD_LAT + 2) tick();
    @(negedge clk);
    checks++;
    if (mem_rd_data_v !== 1'b1) begin
      failures++;
      $display("FAIL midrst_prefill v=%b expected=1", mem_rd_data_v);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_rd_data_v !== 1'b0 || mem_rd_ready !== 1'b0 || mem_rd_data !== 64'h0) begin
      failures++;
      $display("FAIL midrst_async v=%b ready=%b data=%h expected 0/0/0", mem_rd_data_v, mem_rd_ready, mem_rd_data);
    end
    exp_q.delete();
    obs_q.delete();
    mcredit = 4;
    tick();
    tick();
    rst_n = 1'b1;
    mem_rd_data_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_rd_data_v) vcnt++;
      tick();
    end
    checks++;
    if (vcnt != 0 || obs_q.size() != 0 || mem_rd_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_stale v_cycles=%0d out=%0d ready=%b expected 0/0/1", vcnt, obs_q.size(), mem_rd_ready);
    end
    mem_rd_data_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mem_rd_en = 1'b1;
      mem_rd_addr = 16'h02C0 + 16'(acc * 8);
      @(negedge clk);
      if (mem_rd_ready) acc++;
      tick();
    end
    mem_rd_en = 1'b0;
    checks++;
    if (acc != 4) begin
      failures++;
      $display("FAIL midrst_credit accepted=%0d expected=4", acc);
    end
    mem_rd_data_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (obs_q.size() != 4 || exp_q.size() != 4) begin
      failures++;
      $display("FAIL midrst_count out=%0d exp=%0d expected=4", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL midrst_word got=%b/%h expected=%b/%h", o.last, o.data, e.last, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_last();
    test_unaligned();
    test_reset_midstream();
    checks++;
    if (ready_err != 0) begin
      failures++;
      $display("FAIL ready_vs_credit_model errors=%0d expected=0", ready_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
